// File: rtl/serial_subtractor_8bit_if.sv
// Operand/result bundle for serial_subtractor_8bit. The master drives the
// request, the slave returns status, results and a state_dbg view of its FSM.
interface serial_subtractor_8bit_if;
  // Request: start is taken only on a rising edge where ready=1; a, b, bin
  // are captured on that same edge. Later changes do not affect the operation.
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       bin;
  logic       ready;
  logic       busy;
  logic       done;
  logic [7:0] diff;
  logic       bout;
  logic       overflow;
  logic [1:0] state_dbg;

  modport master (
    output start, a, b, bin,
    input  ready, busy, done, diff, bout, overflow, state_dbg
  );

  modport slave (
    input  start, a, b, bin,
    output ready, busy, done, diff, bout, overflow, state_dbg
  );
endinterface

// File: rtl/serial_subtractor_8bit.sv
// Bit-serial 8-bit subtractor: a - b - bin, LSB first, one bit per cycle.
// Define SUB_SATURATE_EN to clamp diff on signed overflow (default: wrap-around).
module serial_subtractor_8bit (
  input logic                      clk,
  input logic                      rst,
  serial_subtractor_8bit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] cnt;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [7:0] d_r;
  logic       br;
  logic       ready_r;
  logic       busy_r;
  logic       done_r;
  logic [7:0] diff_r;
  logic       bout_r;
  logic       ovf_r;

  logic       ai;
  logic       bi;
  logic       d_bit;
  logic       br_next;
  logic [7:0] raw_diff;
  logic       ovf_c;
  logic [7:0] result;

  // Operands shift right each cycle, so bit 0 is always the bit being worked
  // on; on the last cycle ai/bi are the original sign bits.
  always_comb begin
    ai       = a_r[0];
    bi       = b_r[0];
    d_bit    = ai ^ bi ^ br;
    br_next  = (~ai & bi) | (~(ai ^ bi) & br);
    raw_diff = {d_bit, d_r[7:1]};
    ovf_c    = (ai != bi) && (raw_diff[7] != ai);
`ifdef SUB_SATURATE_EN
    if (ovf_c) result = ai ? 8'h80 : 8'h7F;
    else       result = raw_diff;
`else
    result   = raw_diff;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      a_r     <= 8'h00;
      b_r     <= 8'h00;
      d_r     <= 8'h00;
      br      <= 1'b0;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      diff_r  <= 8'h00;
      bout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_r     <= bus.a;
            b_r     <= bus.b;
            br      <= bus.bin;
            d_r     <= 8'h00;
            cnt     <= 3'd0;
            state   <= SHIFT;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
          end
        end
        SHIFT: begin
          a_r <= {1'b0, a_r[7:1]};
          b_r <= {1'b0, b_r[7:1]};
          d_r <= raw_diff;
          br  <= br_next;
          cnt <= cnt + 3'd1;
          // Results are published only here, all three together.
          if (cnt == 3'd7) begin
            state  <= DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            diff_r <= result;
            bout_r <= br_next;
            ovf_r  <= ovf_c;
          end
        end
        DONE: begin
          state   <= IDLE;
          done_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.diff      = diff_r;
  assign bus.bout      = bout_r;
  assign bus.overflow  = ovf_r;
  assign bus.state_dbg = state;

endmodule
